// File: rtl/bus_interconnect.sv
// ---------------------------------------------------------------------------
// bus_interconnect
//
// Shared-bus interconnect: NUM_M masters time-share one bus to NUM_S slaves.
// A registered round-robin arbiter picks the bus owner. The owner's address,
// strobe, direction and write data drive the shared slave-side bus. The top
// SEL_W address bits pick one slave chip select, and that slave's read data
// and ready are returned to every master.
//
// Optional feature (macro BUS_TIMEOUT_EN): a no-response watchdog. If the
// selected slave does not answer within TIMEOUT wait cycles, it forces a
// ready with zero data and pulses bus_err for one cycle.
//
// Ports
//   clk         clock
//   reset       synchronous active-high reset
//   m_req_      per-master bus request (active-low)
//   m_grnt_     per-master bus grant (active-low, one-hot or none)
//   m_addr      packed master addresses, master i at [i*ADDR_W +: ADDR_W]
//   m_as_       per-master address strobe (active-low)
//   m_rw        per-master direction (1 = read, 0 = write)
//   m_wr_data   packed master write data, master i at [i*DATA_W +: DATA_W]
//   s_cs_       per-slave chip select (active-low)
//   s_addr      shared address
//   s_as_       shared address strobe (active-low)
//   s_rw        shared direction
//   s_wr_data   shared write data
//   s_rd_data   packed slave read data, slave j at [j*DATA_W +: DATA_W]
//   s_rdy_      per-slave ready (active-low)
//   m_rd_data   read data returned to all masters
//   m_rdy_      ready returned to all masters (active-low)
//   bus_err     one-cycle pulse on watchdog expiry
// ---------------------------------------------------------------------------
module bus_interconnect #(
  parameter int NUM_M   = 4,
  parameter int NUM_S   = 8,
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_M-1:0]         m_req_,
  output logic [NUM_M-1:0]         m_grnt_,
  input  logic [NUM_M*ADDR_W-1:0]  m_addr,
  input  logic [NUM_M-1:0]         m_as_,
  input  logic [NUM_M-1:0]         m_rw,
  input  logic [NUM_M*DATA_W-1:0]  m_wr_data,
  output logic [NUM_S-1:0]         s_cs_,
  output logic [ADDR_W-1:0]        s_addr,
  output logic                     s_as_,
  output logic                     s_rw,
  output logic [DATA_W-1:0]        s_wr_data,
  input  logic [NUM_S*DATA_W-1:0]  s_rd_data,
  input  logic [NUM_S-1:0]         s_rdy_,
  output logic [DATA_W-1:0]        m_rd_data,
  output logic                     m_rdy_,
  output logic                     bus_err
);

  localparam int MI_W  = $clog2(NUM_M);
  localparam int SEL_W = $clog2(NUM_S);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  arb_state_t        state_q, state_d;
  logic [MI_W-1:0]   owner_q, owner_d;
  logic              own_vld;

  assign own_vld = (state_q == ST_BUSY);

  // -------------------------------------------------------------------------
  // Arbiter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      // Last owner = NUM_M-1 makes the first scan start at master 0.
      owner_q <= MI_W'(NUM_M - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  logic            rr_found;
  logic [MI_W-1:0] rr_cand;
  logic [MI_W:0]   rr_sum;

  // Round-robin scan owner+1, owner+2, ... wrapping at NUM_M. The last
  // candidate is the current owner itself, so an owner that is the only
  // requester after an idle period is granted again.
  always_comb begin
    rr_found = 1'b0;
    rr_cand  = owner_q;
    rr_sum   = '0;
    for (int k = 1; k <= NUM_M; k++) begin
      rr_sum = {1'b0, owner_q} + (MI_W+1)'(k);
      if (rr_sum >= (MI_W+1)'(NUM_M)) begin
        rr_sum = rr_sum - (MI_W+1)'(NUM_M);
      end
      if (!rr_found && !m_req_[rr_sum[MI_W-1:0]]) begin
        rr_found = 1'b1;
        rr_cand  = rr_sum[MI_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ST_BUSY: begin
        // No preemption: the owner keeps the bus while it requests.
        if (m_req_[owner_q]) begin
          if (rr_found) begin
            owner_d = rr_cand;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        if (rr_found) begin
          state_d = ST_BUSY;
          owner_d = rr_cand;
        end
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_M; gi++) begin : g_grant
      assign m_grnt_[gi] = !(own_vld && (owner_q == MI_W'(gi)));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Master-side mux
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] m_addr_arr [NUM_M];
  logic [DATA_W-1:0] m_wd_arr   [NUM_M];
  logic [DATA_W-1:0] s_rd_arr   [NUM_S];

  generate
    for (gi = 0; gi < NUM_M; gi++) begin : g_m_unpack
      assign m_addr_arr[gi] = m_addr[gi*ADDR_W +: ADDR_W];
      assign m_wd_arr[gi]   = m_wr_data[gi*DATA_W +: DATA_W];
    end
    for (gi = 0; gi < NUM_S; gi++) begin : g_s_unpack
      assign s_rd_arr[gi] = s_rd_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_comb begin
    s_addr    = '0;
    s_as_     = 1'b1;
    s_rw      = 1'b1;
    s_wr_data = '0;
    if (own_vld) begin
      s_addr    = m_addr_arr[owner_q];
      s_as_     = m_as_[owner_q];
      s_rw      = m_rw[owner_q];
      s_wr_data = m_wd_arr[owner_q];
    end
  end

  // -------------------------------------------------------------------------
  // Address decode and slave-side mux
  // -------------------------------------------------------------------------
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] rd_mux;
  logic              rdy_mux;

  assign sel = s_addr[ADDR_W-1 -: SEL_W];

  // Chip select is pure decode; it does not wait for the address strobe.
  generate
    for (gi = 0; gi < NUM_S; gi++) begin : g_cs
      assign s_cs_[gi] = !(own_vld && (sel == SEL_W'(gi)));
    end
  endgenerate

  assign rd_mux  = own_vld ? s_rd_arr[sel] : '0;
  assign rdy_mux = own_vld ? s_rdy_[sel]   : 1'b1;

`ifdef BUS_TIMEOUT_EN
  // -------------------------------------------------------------------------
  // No-response watchdog
  // -------------------------------------------------------------------------
  localparam int WC_W = $clog2(TIMEOUT + 1);

  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic            waiting;
  logic            wd_hit;
  logic            owner_change;

  assign waiting      = own_vld && !s_as_ && s_rdy_[sel];
  // A slave answering on the limit cycle is not waiting, so it wins.
  assign wd_hit       = waiting && (wcnt_q == WC_W'(TIMEOUT));
  assign owner_change = (state_d != state_q) || (owner_d != owner_q);

  always_comb begin
    wcnt_d = '0;
    if (waiting && !wd_hit && !owner_change) begin
      wcnt_d = wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

  assign bus_err   = wd_hit;
  assign m_rdy_    = wd_hit ? 1'b0 : rdy_mux;
  assign m_rd_data = wd_hit ? '0   : rd_mux;
`else
  // Without the watchdog a slave that never answers stalls the bus.
  assign bus_err   = 1'b0;
  assign m_rdy_    = rdy_mux;
  assign m_rd_data = rd_mux;
`endif

endmodule

// File: tb/tb_bus_interconnect.sv
// ---------------------------------------------------------------------------
// tb_bus_interconnect
//
// Directed self-checking bench for bus_interconnect with NUM_M=4, NUM_S=8,
// ADDR_W=30, DATA_W=32 and TIMEOUT=4. Watchdog checks are built only when
// BUS_TIMEOUT_EN is defined; otherwise the bench checks that a stalled slave
// never raises bus_err.
// ---------------------------------------------------------------------------
module tb_bus_interconnect;

  localparam int NUM_M   = 4;
  localparam int NUM_S   = 8;
  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic                    clk;
  logic                    reset;
  logic [NUM_M-1:0]        m_req_;
  logic [NUM_M-1:0]        m_grnt_;
  logic [NUM_M*ADDR_W-1:0] m_addr;
  logic [NUM_M-1:0]        m_as_;
  logic [NUM_M-1:0]        m_rw;
  logic [NUM_M*DATA_W-1:0] m_wr_data;
  logic [NUM_S-1:0]        s_cs_;
  logic [ADDR_W-1:0]       s_addr;
  logic                    s_as_;
  logic                    s_rw;
  logic [DATA_W-1:0]       s_wr_data;
  logic [NUM_S*DATA_W-1:0] s_rd_data;
  logic [NUM_S-1:0]        s_rdy_;
  logic [DATA_W-1:0]       m_rd_data;
  logic                    m_rdy_;
  logic                    bus_err;

  int checks = 0;
  int errors = 0;

  bus_interconnect #(
    .NUM_M(NUM_M), .NUM_S(NUM_S), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .m_req_(m_req_), .m_grnt_(m_grnt_),
    .m_addr(m_addr), .m_as_(m_as_), .m_rw(m_rw), .m_wr_data(m_wr_data),
    .s_cs_(s_cs_), .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw),
    .s_wr_data(s_wr_data), .s_rd_data(s_rd_data), .s_rdy_(s_rdy_),
    .m_rd_data(m_rd_data), .m_rdy_(m_rdy_), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int i, input logic [ADDR_W-1:0] a,
                            input logic as_n, input logic rw,
                            input logic [DATA_W-1:0] wd);
    m_addr[i*ADDR_W +: ADDR_W]    = a;
    m_as_[i]                      = as_n;
    m_rw[i]                       = rw;
    m_wr_data[i*DATA_W +: DATA_W] = wd;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    m_req_ = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (m_grnt_ !== 4'b1111 || s_cs_ !== 8'hFF || s_as_ !== 1'b1 ||
        s_rw !== 1'b1 || s_addr !== '0 || s_wr_data !== '0) begin
      errors++;
      $display("FAIL reset_bus: grnt=%b cs=%b as=%b rw=%b addr=%h wd=%h required 1111 11111111 1 1 0 0",
               m_grnt_, s_cs_, s_as_, s_rw, s_addr, s_wr_data);
    end
    checks++;
    if (m_rd_data !== '0 || m_rdy_ !== 1'b1 || bus_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ret: rd=%h rdy=%b err=%b required 0 1 0", m_rd_data, m_rdy_, bus_err);
    end
    $display("reset: grnt=%b cs=%b", m_grnt_, s_cs_);
    tick();
    checks++;
    if (m_grnt_ !== 4'b1110) begin
      errors++;
      $display("FAIL first_grant: got %b required 1110", m_grnt_);
    end
    $display("first grant: grnt=%b", m_grnt_);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (m_grnt_ !== 4'b1110) begin
        errors++;
        $display("FAIL grant_hold: cycle %0d got %b required 1110", c, m_grnt_);
      end
    end
    $display("hold: grnt=%b", m_grnt_);
  endtask

  task automatic test_round_robin();
    logic [NUM_M-1:0] req_v [5];
    logic [NUM_M-1:0] exp_v [5];
    req_v[0] = 4'b0101; exp_v[0] = 4'b1101; // 0 releases, 1 and 3 request
    req_v[1] = 4'b0111; exp_v[1] = 4'b0111; // 1 releases, 3 still requests
    req_v[2] = 4'b1111; exp_v[2] = 4'b1111; // nobody requests -> idle
    req_v[3] = 4'b1010; exp_v[3] = 4'b1110; // idle scan after 3 starts at 0
    req_v[4] = 4'b1011; exp_v[4] = 4'b1011; // 0 releases, 2 takes over
    for (int i = 0; i < 5; i++) begin
      m_req_ = req_v[i];
      tick();
      checks++;
      if (m_grnt_ !== exp_v[i]) begin
        errors++;
        $display("FAIL rr_step%0d: req=%b got %b required %b", i, req_v[i], m_grnt_, exp_v[i]);
      end
      $display("rr step %0d: req=%b grnt=%b", i, req_v[i], m_grnt_);
    end
    checks++;
    if (s_cs_ === 8'hFF) begin
      errors++;
      $display("FAIL rr_cs: got %b required one low bit while busy", s_cs_);
    end
  endtask

  task automatic test_decode();
    // Master 2 owns the bus; other masters carry distinct junk values.
    set_master(0, 30'h3FFF_FFFF, 1'b0, 1'b1, 32'h1111_1111);
    set_master(1, 30'h1234_5678, 1'b0, 1'b1, 32'h2222_2222);
    set_master(3, 30'h0000_0001, 1'b0, 1'b1, 32'h4444_4444);
    set_master(2, {3'b101, 27'h0ABCDE}, 1'b0, 1'b0, 32'hCAFE_F00D);
    s_rdy_ = 8'b1101_1111;
    #1;
    checks++;
    if (s_cs_ !== 8'b1101_1111) begin
      errors++;
      $display("FAIL dec_cs5: got %b required 11011111", s_cs_);
    end
    checks++;
    if (s_addr !== {3'b101, 27'h0ABCDE} || s_as_ !== 1'b0 || s_rw !== 1'b0 ||
        s_wr_data !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL dec_mux: addr=%h as=%b rw=%b wd=%h required %h 0 0 cafef00d",
               s_addr, s_as_, s_rw, s_wr_data, {3'b101, 27'h0ABCDE});
    end
    checks++;
    if (m_rd_data !== 32'hDEAD_BEEF || m_rdy_ !== 1'b0) begin
      errors++;
      $display("FAIL dec_ret5: rd=%h rdy=%b required deadbeef 0", m_rd_data, m_rdy_);
    end
    $display("decode slave5: cs=%b rd=%h rdy=%b", s_cs_, m_rd_data, m_rdy_);

    set_master(2, {3'b000, 27'h55}, 1'b0, 1'b1, 32'h0);
    #1;
    checks++;
    if (s_cs_ !== 8'b1111_1110 || m_rd_data !== 32'h1000_0000 || m_rdy_ !== 1'b1 || s_rw !== 1'b1) begin
      errors++;
      $display("FAIL dec_cs0: cs=%b rd=%h rdy=%b rw=%b required 11111110 10000000 1 1",
               s_cs_, m_rd_data, m_rdy_, s_rw);
    end
    $display("decode slave0: cs=%b rd=%h rdy=%b", s_cs_, m_rd_data, m_rdy_);

    m_as_  = '1;
    s_rdy_ = '1;
    m_req_ = '1;
    tick();
    checks++;
    if (m_grnt_ !== 4'b1111 || s_cs_ !== 8'hFF || m_rdy_ !== 1'b1 || m_rd_data !== '0) begin
      errors++;
      $display("FAIL dec_idle: grnt=%b cs=%b rdy=%b rd=%h required 1111 11111111 1 0",
               m_grnt_, s_cs_, m_rdy_, m_rd_data);
    end
  endtask

  task automatic test_watchdog();
    // Last owner was 2, so master 1 alone is reached after 3 and 0.
    m_req_ = 4'b1101;
    tick();
    checks++;
    if (m_grnt_ !== 4'b1101) begin
      errors++;
      $display("FAIL wd_grant: got %b required 1101", m_grnt_);
    end
    set_master(1, {3'b011, 27'h42}, 1'b0, 1'b1, 32'h0);
    s_rdy_ = '1;
`ifdef BUS_TIMEOUT_EN
    // Wait cycles 1..4: counter 0..3, no error yet.
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++;
      if (bus_err !== 1'b0 || m_rdy_ !== 1'b1) begin
        errors++;
        $display("FAIL wd_early%0d: err=%b rdy=%b required 0 1", c, bus_err, m_rdy_);
      end
      tick();
    end
    // Wait cycle 5: counter at limit.
    #1;
    checks++;
    if (bus_err !== 1'b1 || m_rdy_ !== 1'b0 || m_rd_data !== '0) begin
      errors++;
      $display("FAIL wd_expire: err=%b rdy=%b rd=%h required 1 0 0", bus_err, m_rdy_, m_rd_data);
    end
    $display("watchdog expire: err=%b rdy=%b rd=%h", bus_err, m_rdy_, m_rd_data);
    tick();
    checks++;
    if (bus_err !== 1'b0 || m_rdy_ !== 1'b1) begin
      errors++;
      $display("FAIL wd_pulse: err=%b rdy=%b required 0 1", bus_err, m_rdy_);
    end
    // Counter restarted at 0; four more cycles bring it back to the limit.
    for (int c = 0; c < 4; c++) tick();
    s_rdy_[3] = 1'b0;
    #1;
    checks++;
    if (bus_err !== 1'b0 || m_rdy_ !== 1'b0 || m_rd_data !== 32'h1000_0003) begin
      errors++;
      $display("FAIL wd_slave_wins: err=%b rdy=%b rd=%h required 0 0 10000003",
               bus_err, m_rdy_, m_rd_data);
    end
    $display("slave wins: err=%b rdy=%b rd=%h", bus_err, m_rdy_, m_rd_data);
`else
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (bus_err !== 1'b0 || m_rdy_ !== 1'b1 || m_rd_data !== 32'h1000_0003) begin
        errors++;
        $display("FAIL stall%0d: err=%b rdy=%b rd=%h required 0 1 10000003",
                 c, bus_err, m_rdy_, m_rd_data);
      end
      tick();
    end
    $display("stall without watchdog: err=%b rdy=%b", bus_err, m_rdy_);
`endif
    m_as_  = '1;
    s_rdy_ = '1;
    m_req_ = '1;
    tick();
  endtask

  task automatic test_reset_mid();
    // Last owner was 1: scan 2,3,0,1 lands on master 1 again.
    m_req_ = 4'b1101;
    tick();
    set_master(1, {3'b110, 27'h7}, 1'b0, 1'b0, 32'h5A5A_5A5A);
    tick();
    checks++;
    if (m_grnt_ !== 4'b1101 || s_cs_ !== 8'b1011_1111 || s_as_ !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy: grnt=%b cs=%b as=%b required 1101 10111111 0", m_grnt_, s_cs_, s_as_);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (m_grnt_ !== 4'b1111 || s_cs_ !== 8'hFF || s_as_ !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: grnt=%b cs=%b as=%b required 1111 11111111 1", m_grnt_, s_cs_, s_as_);
    end
    $display("reset mid-transfer: grnt=%b cs=%b as=%b", m_grnt_, s_cs_, s_as_);
    reset = 1'b0;
    tick();
    // Owner reset to 3, so the scan starts at 0 and finds master 1.
    checks++;
    if (m_grnt_ !== 4'b1101) begin
      errors++;
      $display("FAIL post_reset_grant: got %b required 1101", m_grnt_);
    end
    m_req_ = '1;
    m_as_  = '1;
    tick();
  endtask

  initial begin
    reset     = 1'b1;
    m_req_    = '1;
    m_addr    = '0;
    m_as_     = '1;
    m_rw      = '1;
    m_wr_data = '0;
    s_rdy_    = '1;
    for (int j = 0; j < NUM_S; j++) begin
      s_rd_data[j*DATA_W +: DATA_W] = 32'h1000_0000 + j;
    end
    s_rd_data[5*DATA_W +: DATA_W] = 32'hDEAD_BEEF;

    test_reset();
    test_round_robin();
    test_decode();
    test_watchdog();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_interconnect.md
# bus_interconnect

Parametrised shared-bus interconnect connecting NUM_M masters to NUM_S slaves over one time-multiplexed bus, with registered round-robin arbitration, address-based slave select, and an optional no-response watchdog. It sits between the CPU/DMA-class masters and the memory/peripheral slaves and supersedes the fixed 4-master/8-slave bus top. All bus-control signals are active-low (`_` suffix); `rw` is 1 = read, 0 = write.

## Interface
- NUM_M, 4: number of masters, 2..8
- NUM_S, 8: number of slaves, power of two, 2..16
- ADDR_W, 30: word-address width
- DATA_W, 32: data width
- TIMEOUT, 64: watchdog limit in wait cycles, ≥2 (used only with BUS_TIMEOUT_EN)
- Derived: MI_W = clog2(NUM_M), SEL_W = clog2(NUM_S)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m_req_  in  NUM_M  bus request per master, active-low
- m_grnt_  out  NUM_M  bus grant per master, active-low, one-hot-or-none
- m_addr  in  NUM_M*ADDR_W  master addresses, master i at [i*ADDR_W +: ADDR_W]
- m_as_  in  NUM_M  address strobe per master
- m_rw  in  NUM_M  read/write per master
- m_wr_data  in  NUM_M*DATA_W  write data per master
- s_cs_  out  NUM_S  slave chip selects, active-low
- s_addr  out  ADDR_W  shared address
- s_as_  out  1  shared address strobe
- s_rw  out  1  shared read/write
- s_wr_data  out  DATA_W  shared write data
- s_rd_data  in  NUM_S*DATA_W  slave read data, slave j at [j*DATA_W +: DATA_W]
- s_rdy_  in  NUM_S  slave ready, active-low
- m_rd_data  out  DATA_W  read data returned to all masters
- m_rdy_  out  1  ready returned to all masters
- bus_err  out  1  one-cycle pulse, watchdog expiry

## Operation
- Arbiter state: `own_vld`, `owner[MI_W-1:0]`, all registered.
- IDLE (own_vld=0): any m_req_ low → grant first requester scanning owner+1, owner+2, … mod NUM_M; own_vld=1.
- BUSY: owner keeps m_req_[owner] low → hold grant, no preemption. Owner raises m_req_ → same edge grants next requester scanning from owner+1; none requesting → IDLE.
- m_grnt_[i] = !(own_vld && owner==i); all 1 in IDLE.
- Master mux: own_vld → s_addr/s_as_/s_rw/s_wr_data = owner's signals; IDLE → 0 / 1 / 1 / 0.
- Decode: sel = s_addr[ADDR_W-1 -: SEL_W]; s_cs_[sel]=0 when own_vld, others 1; all 1 in IDLE. cs_ is pure decode, independent of s_as_.
- Slave mux: own_vld → m_rd_data = s_rd_data[sel], m_rdy_ = s_rdy_[sel]; IDLE → 0 / 1.
- Watchdog (BUS_TIMEOUT_EN): counter `wcnt`, clog2(TIMEOUT+1) bits. Increments when own_vld && !s_as_ && s_rdy_[sel]. Clears on reset, slave ready, s_as_ high, IDLE, or owner change. When wcnt==TIMEOUT: m_rdy_=0, m_rd_data=0, bus_err=1 for that cycle; wcnt clears next edge.

## Timing
- Reset values (registered): own_vld=0, owner=NUM_M-1 (first grant scan starts at master 0), wcnt=0. Resulting outputs: m_grnt_ all 1, s_cs_ all 1, s_as_=1, s_rw=1, s_addr=0, s_wr_data=0, m_rd_data=0, m_rdy_=1, bus_err=0.
- Request→grant latency: 1 cycle. Release→next grant: same edge, no dead cycle.
- Address/data mux, decode, and read return: combinational, 0 cycles.
- Reset mid-transfer: next edge forces IDLE and clears wcnt, regardless of requests.
- Slave ready in the same cycle wcnt reaches TIMEOUT: the slave wins. Real data and rdy_ pass through, bus_err=0.
- Owner lowers as_ only after grant is observed. A master seeing grant drop must stop the transfer.

## Configuration
- BUS_TIMEOUT_EN defined: watchdog as above.
- Not defined: no wcnt logic, bus_err tied 0, m_rdy_/m_rd_data are pure slave-mux outputs. A hung slave stalls the bus indefinitely.

## Test plan
- Reset with all m_req_=0 (NUM_M=4) → cycle 1 m_grnt_=4'b1110; grant stays on master 0 while its req_ held.
- Master 0 releases while masters 1 and 3 request → next cycle m_grnt_=4'b1101. Master 1 releases → m_grnt_=4'b0111. Master 3 releases, no requests → m_grnt_=4'b1111.
- Master 2 owns bus, s_addr top 3 bits = 3'b101, slave 5 returns rd_data=32'hDEADBEEF, rdy_=0 → s_cs_=8'b1101_1111, m_rd_data=32'hDEADBEEF, m_rdy_=0.
- BUS_TIMEOUT_EN, TIMEOUT=4, slave never ready with as_ low → bus_err=1 and m_rdy_=0, m_rd_data=0 on the 5th wait cycle (wcnt=4), for one cycle only.
- Same setup, slave rdy_=0 on the wcnt==4 cycle → bus_err=0, m_rd_data = slave data.
- Assert reset while master 1 is mid-transfer → next cycle all m_grnt_=1, s_cs_ all 1, s_as_=1.
